// File: rtl/layer_priority_mux.sv
// Per-pixel layer priority mux with transparent colour keying, plus per-frame
// collision detection channels with sticky flags, saturating counts and frame snapshots.
module layer_priority_mux #(
  parameter int                           N_LAYERS      = 8,
  parameter int                           COLOR_W       = 8,
  parameter logic [COLOR_W-1:0]           MASK_VALUE    = 8'h62,
  parameter logic [COLOR_W-1:0]           DEFAULT_COLOR = 8'h76,
  parameter int                           N_COLL        = 4,
  parameter logic [N_COLL*N_LAYERS-1:0]   COLL_A_MASK   = '0,
  parameter logic [N_COLL*N_LAYERS-1:0]   COLL_B_MASK   = '0,
  parameter int                           CNT_W         = 12
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          pixel_valid,
  input  logic                          startOfFrame,
  input  logic [N_LAYERS*COLOR_W-1:0]   layer_colors,
  input  logic [N_LAYERS-1:0]           layer_enable,
  output logic [COLOR_W-1:0]            RGB,
  output logic                          rgb_valid,
  output logic [N_COLL-1:0]             coll_live,
  output logic [N_COLL-1:0]             coll_frame,
  output logic [N_COLL*CNT_W-1:0]       coll_count,
  output logic                          frame_done
);

  // Valid semantics: pixel_valid qualifies the current inputs; rgb_valid is the
  // same flag one cycle later, aligned with RGB. There is no ready/backpressure.

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_LAYERS-1:0] opaque;
  logic [N_COLL-1:0]   hit;
  logic [COLOR_W-1:0]  sel_color;

  logic [N_COLL-1:0]   sticky;
  logic [CNT_W-1:0]    cnt [N_COLL];

  for (genvar i = 0; i < N_LAYERS; i++) begin : g_opaque
    assign opaque[i] = layer_enable[i] &&
                       (layer_colors[i*COLOR_W +: COLOR_W] != MASK_VALUE);
  end

  // Walk from lowest to highest priority so the lowest-index opaque layer wins last.
  always_comb begin
    sel_color = DEFAULT_COLOR;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) sel_color = layer_colors[i*COLOR_W +: COLOR_W];
    end
  end

  // An empty A or B set reduces to zero, so that channel can never hit.
  for (genvar c = 0; c < N_COLL; c++) begin : g_hit
    assign hit[c] = pixel_valid
                  && (|(opaque & COLL_A_MASK[c*N_LAYERS +: N_LAYERS]))
                  && (|(opaque & COLL_B_MASK[c*N_LAYERS +: N_LAYERS]));
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      RGB        <= '0;
      rgb_valid  <= 1'b0;
      coll_live  <= '0;
      coll_frame <= '0;
      coll_count <= '0;
      frame_done <= 1'b0;
      sticky     <= '0;
      cnt        <= '{default: '0};
    end else begin
      RGB        <= sel_color;
      rgb_valid  <= pixel_valid;
      coll_live  <= hit;
      frame_done <= startOfFrame;
      for (int c = 0; c < N_COLL; c++) begin
        if (startOfFrame) begin
          // Snapshot the finished frame; the start-of-frame pixel opens the new one.
          coll_frame[c]                 <= sticky[c];
          coll_count[c*CNT_W +: CNT_W]  <= cnt[c];
          sticky[c]                     <= hit[c];
          cnt[c]                        <= hit[c] ? CNT_ONE : '0;
        end else if (hit[c]) begin
          sticky[c] <= 1'b1;
          if (cnt[c] != CNT_MAX) cnt[c] <= cnt[c] + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: doc/layer_priority_mux.md
Name: layer_priority_mux

Overview:
Parametrised successor to the fixed sprite-priority mux in the VGA display path. It sits between the per-object drawers (player car, AI cars, truck, bonus, finish line, progress bar, message board, background) and the VGA output. It selects one transparent-keyed colour per pixel by priority and drives RGB. It also runs N_COLL configurable collision-detection channels, each with a per-frame sticky flag, a saturating overlap pixel count and a frame-boundary snapshot for the game controller.

Parameters:
N_LAYERS, 8, number of colour layers; layer 0 has the highest priority.
COLOR_W, 8, bits per layer colour and per RGB output.
MASK_VALUE, 8'h62, transparent colour key.
DEFAULT_COLOR, 8'h76, output colour when no enabled layer is opaque.
N_COLL, 4, number of collision channels.
COLL_A_MASK, all-zero vector of N_COLL*N_LAYERS bits, layer set A per channel; channel c uses bits [c*N_LAYERS +: N_LAYERS].
COLL_B_MASK, all-zero vector of N_COLL*N_LAYERS bits, layer set B per channel, same packing.
CNT_W, 12, width of each overlap pixel counter.

Ports:
clk  input  1  system clock, pixel-rate enable domain.
resetN  input  1  synchronous, active-high reset (1 = reset), sampled on the clk rising edge.
pixel_valid  input  1  current inputs form a visible pixel.
startOfFrame  input  1  one-cycle pulse at the first pixel of each frame.
layer_colors  input  N_LAYERS*COLOR_W  packed layer colours; layer i uses [i*COLOR_W +: COLOR_W].
layer_enable  input  N_LAYERS  per-layer enable; a disabled layer is treated as transparent.
RGB  output  COLOR_W  selected colour, registered.
rgb_valid  output  1  pixel_valid delayed to align with RGB.
coll_live  output  N_COLL  per-channel overlap on the pixel currently shown on RGB.
coll_frame  output  N_COLL  per-channel sticky flags of the previous frame, updated at startOfFrame.
coll_count  output  N_COLL*CNT_W  per-channel overlap pixel counts of the previous frame, saturating.
frame_done  output  1  one-cycle pulse when coll_frame and coll_count update.

Behaviour:
- Opaque(i) = layer_enable[i] AND layer_colors[i] != MASK_VALUE.
- Selection: the lowest-index opaque layer wins. If no layer is opaque, RGB = DEFAULT_COLOR.
- Latency: exactly 1 cycle for RGB, rgb_valid and coll_live. There is no stall and no backpressure.
- When pixel_valid = 0: RGB is still updated from the selection logic, rgb_valid = 0, coll_live = 0, and the accumulators do not change.
- Channel c hit = pixel_valid AND (any opaque layer in A_c) AND (any opaque layer in B_c). A layer in both A_c and B_c counts for both sets, so a single opaque layer in both sets produces a hit. A channel with an empty A_c or B_c never hits.
- Accumulators, per channel: sticky_c and cnt_c. On a hit, sticky_c is set and cnt_c increments, saturating at 2^CNT_W - 1 with no wrap.
- Frame boundary, on a cycle with startOfFrame = 1:
  - coll_frame[c] <= sticky_c and coll_count_c <= cnt_c, using the values accumulated before this cycle.
  - frame_done <= 1.
  - sticky_c and cnt_c are reloaded from this cycle's hit (1 / 1 if hit, else 0 / 0). The startOfFrame pixel belongs to the new frame.
- Two consecutive startOfFrame cycles: the second snapshot holds only the first pulse's pixel.
- Reset (resetN = 1 at the clk edge): RGB = 0, rgb_valid = 0, coll_live = 0, coll_frame = 0, coll_count = 0, frame_done = 0, all sticky and cnt = 0. Reset takes priority over startOfFrame and pixel_valid in the same cycle. Reset mid-frame discards that partial frame, and no frame_done pulse is issued for it.
- Changes to layer_enable take effect on the next pixel with no glitch. The selection uses only the current cycle's inputs.
- Implementation: a generate-based priority chain plus per-channel reduction ORs. The Mask parameters are elaborated at compile time, with no runtime configuration.

Test Plan:
- Priority: layers 0..7 = 62,62,1C,E0,62,62,62,00, all enabled -> RGB = 1C one cycle later. Disable layer 2 -> RGB = E0.
- Default: all layers 62, or layer_enable = 0 -> RGB = 76. Asserting resetN -> RGB = 00 and every output 0 on the next edge.
- Collision: ch0 A = {0}, B = {3}. Layers 0 and 3 opaque for 5 valid pixels within a frame, then startOfFrame -> coll_frame[0] = 1, coll_count0 = 5, frame_done pulses once. coll_live[0] is high for 5 cycles, each lagging its input by 1.
- Boundary ownership: hit on the startOfFrame cycle only -> snapshot count = 0. On the next startOfFrame, count = 1.
- Saturation: CNT_W = 3 with 12 hits in one frame -> coll_count = 7.
- pixel_valid = 0 with overlapping layers -> no count and coll_live = 0, but RGB still follows the priority winner.
